// File: rtl/viterbi_link_sequencer.sv
// Frame sequencer for the encoder -> channel -> decoder link: payload/tail generation, scheduled
// channel bit flips and residual-error counting. Define SEQ_LFSR_EN for an LFSR payload.
module viterbi_link_sequencer #(
  parameter int          FRAME_LEN  = 256,
  parameter int          TAIL_LEN   = 2,
  parameter int          DEC_LAT    = 8,
  parameter int          ERR_PERIOD = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  output logic        enc_d_o,
  output logic        enc_en_o,
  input  logic        enc_valid_i,
  input  logic [1:0]  enc_sym_i,
  output logic [1:0]  chan_sym_o,
  output logic        dec_en_o,
  input  logic        dec_d_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] inj_ct_o,
  output logic [15:0] bit_err_ct_o
);
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_FLUSH, S_DRAIN, S_DONE} state_t;

  localparam int              PH_W       = $clog2(ERR_PERIOD);
  localparam logic [15:0]     FRAME_LAST = 16'(FRAME_LEN - 1);
  localparam logic [15:0]     TAIL_LAST  = 16'(TAIL_LEN - 1);
  localparam logic [15:0]     FRAME_CT   = 16'(FRAME_LEN);
  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(ERR_PERIOD - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

`ifdef SEQ_LFSR_EN
  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward the MSB output.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [15:0] pay_q;
`endif

  state_t             state_q;
  logic [15:0]        cnt_q, cmp_q, inj_q, err_q;
  logic [15:0]        cmp_d, inj_d, err_d;
  logic [1:0]         mode_q, chan_q;
  logic               enc_d_q, enc_en_q, busy_q, done_q, dec_en_q;
  logic [PH_W-1:0]    ph_q;
  logic               seen_q;
  logic [DEC_LAT-1:0] dl_v_q, dl_b_q;
  logic               tap_v, tap_b, sym_ok, flip, fin, accept;

  always_comb begin
    tap_v  = dl_v_q[DEC_LAT-1];
    tap_b  = dl_b_q[DEC_LAT-1];
    sym_ok = enc_valid_i && (state_q != S_IDLE);
    accept = (state_q == S_IDLE) && start_i;
    case (mode_q)
      2'b01:   flip = sym_ok && (ph_q == PH_LAST);
      2'b10:   flip = sym_ok && ((ph_q == PH_LAST) || (seen_q && ph_q == '0));
      default: flip = 1'b0;
    endcase
    cmp_d = cmp_q + {15'd0, tap_v};
    inj_d = sat_inc(inj_q, flip);
    err_d = sat_inc(err_q, tap_v && (tap_b != dec_d_i));
    fin   = (cmp_d == FRAME_CT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mode_q   <= '0;
      enc_d_q  <= 1'b0;
      enc_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_LFSR_EN
      pay_q    <= LFSR_SEED;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          state_q  <= S_SEND;
          mode_q   <= mode_i;
          cnt_q    <= '0;
          enc_en_q <= 1'b1;
          busy_q   <= 1'b1;
`ifdef SEQ_LFSR_EN
          enc_d_q  <= LFSR_SEED[15];
          pay_q    <= lfsr_step(LFSR_SEED);
`else
          enc_d_q  <= 1'b0;
`endif
        end
        S_SEND: begin
          cnt_q <= cnt_q + 16'd1;
`ifdef SEQ_LFSR_EN
          enc_d_q <= pay_q[15];
          pay_q   <= lfsr_step(pay_q);
`else
          enc_d_q <= ~cnt_q[0];
`endif
          if (cnt_q == FRAME_LAST) begin
            cnt_q   <= '0;
            enc_d_q <= 1'b0;
            if (TAIL_LEN > 0) begin
              state_q <= S_FLUSH;
            end else begin
              state_q  <= S_DRAIN;
              enc_en_q <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == TAIL_LAST) begin
            enc_en_q <= 1'b0;
            // Short decoder latency can finish all compares inside the tail.
            if (fin) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: if (fin) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Channel corruption, reference delay line and frame counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_q   <= '0;
      dec_en_q <= 1'b0;
      dl_v_q   <= '0;
      dl_b_q   <= '0;
      inj_q    <= '0;
      err_q    <= '0;
      cmp_q    <= '0;
      ph_q     <= '0;
      seen_q   <= 1'b0;
    end else begin
      chan_q    <= enc_sym_i ^ {1'b0, flip};
      dec_en_q  <= enc_valid_i;
      dl_v_q[0] <= (state_q == S_SEND);
      dl_b_q[0] <= enc_d_q;
      for (int i = 1; i < DEC_LAT; i++) begin
        dl_v_q[i] <= dl_v_q[i-1];
        dl_b_q[i] <= dl_b_q[i-1];
      end
      if (accept) begin
        inj_q  <= '0;
        err_q  <= '0;
        cmp_q  <= '0;
        ph_q   <= '0;
        seen_q <= 1'b0;
      end else begin
        inj_q <= inj_d;
        err_q <= err_d;
        cmp_q <= cmp_d;
        if (sym_ok) begin
          ph_q   <= (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
          seen_q <= 1'b1;
        end
      end
    end
  end

  assign enc_d_o      = enc_d_q;
  assign enc_en_o     = enc_en_q;
  assign chan_sym_o   = chan_q;
  assign dec_en_o     = dec_en_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign inj_ct_o     = inj_q;
  assign bit_err_ct_o = err_q;
endmodule
